// File: rtl/kalman_update_mc.sv
// Multi-channel Kalman state update: angle += K0*y, bias += K1*y with one shared
// multiplier over two phases, per-channel bias storage and saturating sums.
module kalman_update_mc #(
    parameter int  DATA_W    = 16,
    parameter int  GAIN_W    = 13,
    parameter int  GAIN_FRAC = 13,
    parameter int  NUM_CH    = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [GAIN_W-1:0] in_k0,
    input  logic [GAIN_W-1:0] in_k1,
    input  logic [DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0] in_angle,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_angle,
    output logic [DATA_W-1:0] out_bias,
    output logic [1:0]        out_sat,
    output logic              out_err,
    input  logic              bias_wr,
    input  logic [CH_W-1:0]   bias_wr_ch,
    input  logic [DATA_W-1:0] bias_wr_data
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int SUM_W  = DATA_W + 2;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (DATA_W - 1)));

    typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [GAIN_W-1:0]        k0_q, k0_d, k1_q, k1_d;
    logic signed [DATA_W-1:0] y_q, y_d, angle_q, angle_d, bias_q, bias_d;
    logic                     err_q, err_d;
    logic signed [DATA_W-1:0] bias_reg_q [NUM_CH];
    logic signed [DATA_W-1:0] bias_reg_d [NUM_CH];
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic signed [DATA_W-1:0] out_angle_q, out_angle_d, out_bias_q, out_bias_d;
    logic [1:0]               out_sat_q, out_sat_d;
    logic                     out_err_q, out_err_d;

    logic [GAIN_W-1:0]        k_sel;
    logic signed [DATA_W-1:0] prior, cap_bias;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  prod_sh, sum;

    function automatic logic signed [DATA_W-1:0] sat_val(input logic signed [SUM_W-1:0] s);
        if (s > SAT_MAX)      return DATA_W'(SAT_MAX);
        else if (s < SAT_MIN) return DATA_W'(SAT_MIN);
        else                  return DATA_W'(s);
    endfunction

    function automatic logic sat_flag(input logic signed [SUM_W-1:0] s);
        return (s > SAT_MAX) || (s < SAT_MIN);
    endfunction

    // Shared multiplier: K0/angle in MUL_A, K1/bias in MUL_B; >>> floors toward -inf
    always_comb begin
        k_sel   = (state_q == MUL_B) ? k1_q : k0_q;
        prior   = (state_q == MUL_B) ? bias_q : angle_q;
        prod    = PROD_W'(y_q) * PROD_W'($signed({1'b0, k_sel}));
        prod_sh = SUM_W'(prod >>> GAIN_FRAC);
        sum     = prod_sh + SUM_W'(prior);
    end

    always_comb begin
        cap_bias = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) cap_bias = bias_reg_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        k0_d        = k0_q;
        k1_d        = k1_q;
        y_d         = y_q;
        angle_d     = angle_q;
        bias_d      = bias_q;
        err_d       = err_q;
        bias_reg_d  = bias_reg_q;
        out_ch_d    = out_ch_q;
        out_angle_d = out_angle_q;
        out_bias_d  = out_bias_q;
        out_sat_d   = out_sat_q;
        out_err_d   = out_err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = MUL_A;
                    ch_d    = in_ch;
                    k0_d    = in_k0;
                    k1_d    = in_k1;
                    y_d     = $signed(in_y);
                    angle_d = $signed(in_angle);
                    bias_d  = cap_bias;
                    err_d   = ({1'b0, in_ch} >= NUM_CH_L);
                end
            end
            MUL_A: begin
                state_d     = MUL_B;
                out_ch_d    = ch_q;
                out_err_d   = err_q;
                out_angle_d = err_q ? angle_q : sat_val(sum);
                out_sat_d   = {1'b0, ~err_q & sat_flag(sum)};
            end
            MUL_B: begin
                state_d      = DONE;
                out_bias_d   = err_q ? '0 : sat_val(sum);
                out_sat_d[1] = ~err_q & sat_flag(sum);
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!err_q && ch_q == CH_W'(i)) bias_reg_d[i] = sat_val(sum);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Direct load comes last so it overrides a same-cycle writeback
        if (bias_wr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bias_wr_ch == CH_W'(i)) bias_reg_d[i] = $signed(bias_wr_data);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            bias_reg_q  <= '{default: '0};
            out_ch_q    <= '0;
            out_angle_q <= '0;
            out_bias_q  <= '0;
            out_sat_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bias_reg_q  <= bias_reg_d;
            out_ch_q    <= out_ch_d;
            out_angle_q <= out_angle_d;
            out_bias_q  <= out_bias_d;
            out_sat_q   <= out_sat_d;
            out_err_q   <= out_err_d;
        end
    end

    // Request capture registers only matter after an accept, so they carry no reset
    always_ff @(posedge clk) begin
        ch_q    <= ch_d;
        k0_q    <= k0_d;
        k1_q    <= k1_d;
        y_q     <= y_d;
        angle_q <= angle_d;
        bias_q  <= bias_d;
        err_q   <= err_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_ch    = out_ch_q;
    assign out_angle = out_angle_q;
    assign out_bias  = out_bias_q;
    assign out_sat   = out_sat_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_kalman_update_mc.sv
// Bench for kalman_update_mc: fixed vector table, hand sequences for handshake,
// writeback collisions and reset, then random requests against a floor-division model.
module tb_kalman_update_mc;
    localparam int DATA_W    = 16;
    localparam int GAIN_W    = 13;
    localparam int GAIN_FRAC = 13;
    localparam int NUM_CH    = 3;
    localparam int CH_W      = 2;
    localparam int MAXV      = (1 << (DATA_W - 1)) - 1;
    localparam int MINV      = -(1 << (DATA_W - 1));

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              in_valid, in_ready, out_valid, out_ready, out_err, bias_wr;
    logic [CH_W-1:0]   in_ch, out_ch, bias_wr_ch;
    logic [GAIN_W-1:0] in_k0, in_k1;
    logic [DATA_W-1:0] in_y, in_angle, out_angle, out_bias, bias_wr_data;
    logic [1:0]        out_sat;

    int errors = 0;
    int checks = 0;
    int bias_m [NUM_CH];
    int acc [$];

    typedef struct {
        int ch; int k0; int k1; int y; int ang; int pre_en; int pre;
        int e_angle; int e_bias; int e_sat; int e_err;
    } vec_t;
    vec_t tbl [8];

    kalman_update_mc #(
        .DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC), .NUM_CH(NUM_CH)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_k0(in_k0), .in_k1(in_k1), .in_y(in_y), .in_angle(in_angle),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_angle(out_angle), .out_bias(out_bias), .out_sat(out_sat), .out_err(out_err),
        .bias_wr(bias_wr), .bias_wr_ch(bias_wr_ch), .bias_wr_data(bias_wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: prior + floor(y*K / 2^GAIN_FRAC), clipped to the DATA_W range
    function automatic int floor_scale(input int y, input int k);
        int p, q;
        p = y * k;
        q = p / (1 << GAIN_FRAC);
        if (p < 0 && q * (1 << GAIN_FRAC) != p) q = q - 1;
        return q;
    endfunction

    function automatic void upd(input int prior, input int y, input int k,
                                output int res, output int sat);
        res = prior + floor_scale(y, k);
        sat = 0;
        if (res > MAXV) begin res = MAXV; sat = 1; end
        else if (res < MINV) begin res = MINV; sat = 1; end
    endfunction

    task automatic model_req(input int ch, input int k0, input int k1, input int y, input int ang,
                             input int wr_mode, input int wr_data,
                             output int ea, output int eb, output int es, output int ee);
        int sa, sb;
        if (ch >= NUM_CH) begin
            ea = ang; eb = 0; es = 0; ee = 1;
        end else begin
            upd(ang, y, k0, ea, sa);
            upd(bias_m[ch], y, k1, eb, sb);
            es = sa + 2 * sb;
            ee = 0;
            bias_m[ch] = (wr_mode == 2) ? wr_data : eb;
        end
    endtask

    task automatic write_bias(input int ch, input int d);
        @(negedge clk);
        bias_wr = 1'b1; bias_wr_ch = CH_W'(ch); bias_wr_data = DATA_W'(d);
        @(negedge clk);
        bias_wr = 1'b0;
        if (ch < NUM_CH) bias_m[ch] = d;
    endtask

    // wr_mode: 0 none, 1 bias_wr in the accept cycle, 2 bias_wr in the MUL_B cycle
    task automatic run_req(input int ch, input int k0, input int k1, input int y, input int ang,
                           input int wr_mode, input int wr_data, input int hold,
                           output int oa, output int ob, output int os, output int oe, output int oc);
        int n, lat;
        @(negedge clk);
        in_valid = 1'b1; in_ch = CH_W'(ch); in_k0 = GAIN_W'(k0); in_k1 = GAIN_W'(k1);
        in_y = DATA_W'(y); in_angle = DATA_W'(ang);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check("in_ready_wait", int'(n < 50), 1);
        if (wr_mode == 1) begin
            bias_wr = 1'b1; bias_wr_ch = CH_W'(ch); bias_wr_data = DATA_W'(wr_data);
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            bias_wr = 1'b0;
            if (lat == 1) out_ready = (hold == 0);
            if (wr_mode == 2 && lat == 2) begin
                bias_wr = 1'b1; bias_wr_ch = CH_W'(ch); bias_wr_data = DATA_W'(wr_data);
            end
        end while (!out_valid && lat < 20);
        check("latency", lat, 3);
        oa = int'($signed(out_angle)); ob = int'($signed(out_bias));
        os = int'(out_sat); oe = int'(out_err); oc = int'(out_ch);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_angle", int'($signed(out_angle)), oa);
            check("hold_bias", int'($signed(out_bias)), ob);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_after", int'(in_ready), 1);
        check("valid_after", int'(out_valid), 0);
    endtask

    task automatic req_model(input string tag, input int ch, input int k0, input int k1,
                             input int y, input int ang, input int wr_mode, input int wr_data,
                             input int hold);
        int ea, eb, es, ee, oa, ob, os, oe, oc;
        model_req(ch, k0, k1, y, ang, wr_mode, wr_data, ea, eb, es, ee);
        run_req(ch, k0, k1, y, ang, wr_mode, wr_data, hold, oa, ob, os, oe, oc);
        check({tag, "_angle"}, oa, ea);
        check({tag, "_bias"}, ob, eb);
        check({tag, "_sat"}, os, es);
        check({tag, "_err"}, oe, ee);
        check({tag, "_ch"}, oc, ch);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_ch"}, int'(out_ch), 0);
        check({tag, "_out_angle"}, int'(out_angle), 0);
        check({tag, "_out_bias"}, int'(out_bias), 0);
        check({tag, "_out_sat"}, int'(out_sat), 0);
        check({tag, "_out_err"}, int'(out_err), 0);
    endtask

    initial begin
        int oa, ob, os, oe, oc, n;
        int ch, k0, k1, y, ang, wm, wd;
        in_valid = 1'b0; in_ch = '0; in_k0 = '0; in_k1 = '0; in_y = '0; in_angle = '0;
        out_ready = 1'b1; bias_wr = 1'b0; bias_wr_ch = '0; bias_wr_data = '0;
        foreach (bias_m[i]) bias_m[i] = 0;

        tbl[0] = '{0, 'h1000, 'h0800, 100, 1000, 1, 0, 1050, 25, 0, 0};
        tbl[1] = '{1, 0, 'h0800, -3, 0, 1, 10, 0, 9, 0, 0};
        tbl[2] = '{0, 'h1FFF, 0, 100, 32760, 0, 0, 32767, 25, 1, 0};
        tbl[3] = '{0, 'h1FFF, 0, -100, -32760, 0, 0, -32768, 25, 1, 0};
        tbl[4] = '{2, 0, 'h1FFF, 32767, 5, 1, 32000, 5, 32767, 2, 0};
        tbl[5] = '{1, 'h0800, 'h1FFF, -32768, 100, 1, -32000, -8092, -32768, 2, 0};
        tbl[6] = '{3, 'h1000, 'h0800, 100, 1234, 1, 777, 1234, 0, 0, 1};
        tbl[7] = '{0, 1, 1, -1, 0, 1, 0, -1, -1, 0, 0};

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        n_rst = 1'b1;
        @(negedge clk);
        check("por_in_ready", int'(in_ready), 1);

        foreach (tbl[i]) begin
            if (tbl[i].pre_en != 0) write_bias(tbl[i].ch, tbl[i].pre);
            run_req(tbl[i].ch, tbl[i].k0, tbl[i].k1, tbl[i].y, tbl[i].ang, 0, 0, 0,
                    oa, ob, os, oe, oc);
            check($sformatf("v%0d_angle", i), oa, tbl[i].e_angle);
            check($sformatf("v%0d_bias", i), ob, tbl[i].e_bias);
            check($sformatf("v%0d_sat", i), os, tbl[i].e_sat);
            check($sformatf("v%0d_err", i), oe, tbl[i].e_err);
            check($sformatf("v%0d_ch", i), oc, tbl[i].ch);
            if (tbl[i].ch < NUM_CH) bias_m[tbl[i].ch] = tbl[i].e_bias;
        end

        // Persisted biases seen through zero-gain requests
        req_model("persist0", 0, 0, 0, 0, 0, 0, 0, 0);
        req_model("persist1", 1, 0, 0, 0, 0, 0, 0, 0);

        // bias_wr colliding with the MUL_B writeback wins the register
        write_bias(0, 300);
        run_req(0, 0, 'h1000, 14, 0, 2, 500, 0, oa, ob, os, oe, oc);
        check("wb_collide_out_bias", ob, 307);
        bias_m[0] = 500;
        req_model("wb_collide_reg", 0, 0, 0, 0, 0, 0, 0, 0);

        // bias_wr in the accept cycle: capture sees old value, writeback then overwrites
        write_bias(1, 40);
        run_req(1, 0, 'h1000, -20, 0, 1, 999, 0, oa, ob, os, oe, oc);
        check("acc_collide_out_bias", ob, 30);
        bias_m[1] = 30;
        req_model("acc_collide_reg", 1, 0, 0, 0, 0, 0, 0, 0);

        // Stalled consumer
        req_model("hold", 2, 'h1000, 'h0400, 8, 10, 0, 0, 5);

        // Back-to-back acceptance spacing
        @(negedge clk);
        in_valid = 1'b1; in_ch = '0; in_k0 = '0; in_k1 = '0; in_y = DATA_W'(5); in_angle = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (in_ready) acc.push_back(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_count", acc.size(), 4);
        for (int j = 1; j < acc.size(); j++) check("b2b_gap", acc[j] - acc[j-1], 4);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check("b2b_drain", int'(n < 20), 1);

        // Reset in MUL_A drops the request and clears all biases
        @(negedge clk);
        in_valid = 1'b1; in_ch = '0; in_k0 = GAIN_W'('h1000); in_k1 = GAIN_W'('h1000);
        in_y = DATA_W'(100); in_angle = DATA_W'(1);
        @(negedge clk);
        in_valid = 1'b0;
        n_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_no_valid", int'(out_valid), 0);
        end
        foreach (bias_m[i]) bias_m[i] = 0;
        run_req(0, 0, 'h1000, 14, 0, 0, 0, 0, oa, ob, os, oe, oc);
        check("rst_bias_ch0", ob, 7);
        bias_m[0] = 7;
        req_model("rst_bias_ch1", 1, 0, 0, 0, 0, 0, 0, 0);
        req_model("rst_bias_ch2", 2, 0, 0, 0, 0, 0, 0, 0);
        req_model("err_after_rst", NUM_CH, 'h1FFF, 'h1FFF, 300, -4321, 0, 0, 0);

        // Randomized requests with occasional bias_wr collisions
        for (int i = 0; i < 40; i++) begin
            ch  = int'($urandom_range(0, 3));
            k0  = int'($urandom_range(0, (1 << GAIN_W) - 1));
            k1  = int'($urandom_range(0, (1 << GAIN_W) - 1));
            y   = int'($urandom_range(0, 65535)) - 32768;
            ang = int'($urandom_range(0, 65535)) - 32768;
            wm  = int'($urandom_range(0, 2));
            wd  = int'($urandom_range(0, 65535)) - 32768;
            req_model($sformatf("rnd%0d", i), ch, k0, k1, y, ang, wm, wd, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
